// File: rtl/gtp_link_ctrl_pkg.sv
// Shared definitions for the GTP lane link controller.
//   - link_state_e : FSM state encoding, also exported on state_o
//   - BUFST_*      : GT RX elastic buffer status codes that signal an error
//   - IDLE_*_DEF   : default IDLE (comma) word and its charisk pattern
package gtp_link_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_GT  = 3'd0,
        ST_ALIGN    = 3'd1,
        ST_STABLE   = 3'd2,
        ST_UP       = 3'd3,
        ST_BUF_RST  = 3'd4,
        ST_FAIL     = 3'd5
    } link_state_e;

    localparam logic [2:0]  BUFST_UNDERFLOW = 3'b101;
    localparam logic [2:0]  BUFST_OVERFLOW  = 3'b110;

    localparam logic [15:0] IDLE_WORD_DEF   = 16'hbc95;
    localparam logic [1:0]  IDLE_K_DEF      = 2'b10;

    function automatic logic is_buf_err(input logic [2:0] st);
        return (st == BUFST_UNDERFLOW) || (st == BUFST_OVERFLOW);
    endfunction

endpackage

// File: rtl/gtp_tx_idle_sched.sv
// TX slot scheduler: free-running slot counter, user-ready generation and
// the registered TX mux. Slot 0 of every period is always an IDLE word so the
// far end gets a steady supply of commas for clock correction.
//   usrclk_i, rst_n_i    : clock, async active-low reset
//   link_up_i            : registered link-up from the controller
//   tx_data_i/tx_valid_i : user word and its valid
//   tx_ready_o           : user word accepted this cycle if valid
//   tx_data_o/tx_k_o     : registered word and charisk to the GT
module gtp_tx_idle_sched
    import gtp_link_ctrl_pkg::*;
#(
    parameter logic [15:0] g_IDLE        = IDLE_WORD_DEF,
    parameter logic [1:0]  g_IDLE_K      = IDLE_K_DEF,
    parameter int          g_IDLE_PERIOD = 193
) (
    input  logic        usrclk_i,
    input  logic        rst_n_i,
    input  logic        link_up_i,
    input  logic [15:0] tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [15:0] tx_data_o,
    output logic [1:0]  tx_k_o
);

    localparam int SW = $clog2(g_IDLE_PERIOD);

    logic [SW-1:0] slot_q, slot_d;
    logic [15:0]   data_q, data_d;
    logic [1:0]    k_q, k_d;

    always_comb begin
        slot_d     = (slot_q == SW'(g_IDLE_PERIOD - 1)) ? '0 : slot_q + SW'(1);
        tx_ready_o = link_up_i && (slot_q != '0);
        data_d     = g_IDLE;
        k_d        = g_IDLE_K;
        if (tx_valid_i && tx_ready_o) begin
            data_d = tx_data_i;
            k_d    = 2'b00;
        end
    end

    always_ff @(posedge usrclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_q <= '0;
            data_q <= g_IDLE;
            k_q    <= g_IDLE_K;
        end else begin
            slot_q <= slot_d;
            data_q <= data_d;
            k_q    <= k_d;
        end
    end

    assign tx_data_o = data_q;
    assign tx_k_o    = k_q;

endmodule

// File: rtl/gtp_link_ctrl.sv
// Link bring-up and supervision for one GTP lane (16-bit 8b/10b, RX elastic
// buffer). Walks WAIT_GT -> ALIGN -> STABLE -> UP, recovers from alignment or
// buffer faults via an RX buffer reset pulse, and latches FAIL once the
// consecutive-retry budget is spent.
//   usrclk_i, rst_n_i           : clock, async active-low reset
//   gt_reset_done_i             : GT reset sequence complete
//   rx_aligned_i, rx_bufstatus_i, rx_data_i, rx_k_i : RX side status/data
//   rx_realign_o, rx_buf_reset_o: GT RX controls (registered)
//   tx_data_i/tx_valid_i/tx_ready_o, tx_data_o/tx_k_o : TX path
//   link_up_o, link_fail_o, retry_cnt_o, state_o     : status (registered)
module gtp_link_ctrl
    import gtp_link_ctrl_pkg::*;
#(
    parameter logic [15:0] g_IDLE           = IDLE_WORD_DEF,
    parameter logic [1:0]  g_IDLE_K         = IDLE_K_DEF,
    parameter int          g_IDLE_PERIOD    = 193,
    parameter int          g_ALIGN_TIMEOUT  = 4096,
    parameter int          g_STABLE_CYCLES  = 256,
    parameter int          g_BUF_RST_CYCLES = 8,
    parameter int          g_MAX_RETRIES    = 3
) (
    input  logic        usrclk_i,
    input  logic        rst_n_i,
    input  logic        gt_reset_done_i,
    input  logic        rx_aligned_i,
    input  logic [2:0]  rx_bufstatus_i,
    input  logic [15:0] rx_data_i,
    input  logic [1:0]  rx_k_i,
    output logic        rx_realign_o,
    output logic        rx_buf_reset_o,
    input  logic [15:0] tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [15:0] tx_data_o,
    output logic [1:0]  tx_k_o,
    output logic        link_up_o,
    output logic        link_fail_o,
    output logic [7:0]  retry_cnt_o,
    output logic [2:0]  state_o
);

    localparam int ATW = $clog2(g_ALIGN_TIMEOUT + 1);
    localparam int STW = $clog2(g_STABLE_CYCLES + 1);
    localparam int BRW = $clog2(g_BUF_RST_CYCLES + 1);
    localparam int CRW = $clog2(g_MAX_RETRIES + 2);

    link_state_e    state_q, state_d;
    logic [ATW-1:0] align_tmr_q, align_tmr_d;
    logic [STW-1:0] stable_cnt_q, stable_cnt_d;
    logic [BRW-1:0] buf_cnt_q, buf_cnt_d;
    logic [CRW-1:0] consec_q, consec_d;
    logic [7:0]     retry_q, retry_d;
    logic           realign_q, realign_d;
    logic           buf_rst_q, buf_rst_d;
    logic           up_q, up_d;
    logic           fail_q, fail_d;

    logic buf_err, clean_word, go_align, enter_buf_rst;

    always_comb begin
        state_d       = state_q;
        align_tmr_d   = align_tmr_q;
        stable_cnt_d  = stable_cnt_q;
        buf_cnt_d     = buf_cnt_q;
        consec_d      = consec_q;
        retry_d       = retry_q;
        go_align      = 1'b0;
        enter_buf_rst = 1'b0;

        buf_err    = is_buf_err(rx_bufstatus_i);
        clean_word = (rx_k_i == 2'b00) ||
                     ((rx_k_i == g_IDLE_K) && (rx_data_i == g_IDLE));

        // Losing the GT reset-done overrides everything but the sticky FAIL.
        if (state_q != ST_FAIL && !gt_reset_done_i) begin
            state_d = ST_WAIT_GT;
        end else begin
            case (state_q)
                ST_WAIT_GT: go_align = 1'b1;
                ST_ALIGN: begin
                    if (rx_aligned_i) begin
                        state_d      = ST_STABLE;
                        stable_cnt_d = '0;
                    end else if (align_tmr_q == ATW'(g_ALIGN_TIMEOUT - 1)) begin
                        enter_buf_rst = 1'b1;
                    end else begin
                        align_tmr_d = align_tmr_q + ATW'(1);
                    end
                end
                ST_STABLE: begin
                    // Buffer error wins over a simultaneous alignment loss.
                    if (buf_err)                enter_buf_rst = 1'b1;
                    else if (!rx_aligned_i)     go_align      = 1'b1;
                    else if (!clean_word)       enter_buf_rst = 1'b1;
                    else if (stable_cnt_q == STW'(g_STABLE_CYCLES - 1)) begin
                        state_d  = ST_UP;
                        consec_d = '0;
                    end else begin
                        stable_cnt_d = stable_cnt_q + STW'(1);
                    end
                end
                ST_UP: begin
                    if (buf_err)                enter_buf_rst = 1'b1;
                    else if (!rx_aligned_i)     go_align      = 1'b1;
                    else if (!clean_word)       enter_buf_rst = 1'b1;
                end
                ST_BUF_RST: begin
                    if (buf_cnt_q == BRW'(g_BUF_RST_CYCLES - 1)) go_align = 1'b1;
                    else buf_cnt_d = buf_cnt_q + BRW'(1);
                end
                default: ;  // FAIL holds until reset
            endcase
        end

        if (go_align) begin
            state_d     = ST_ALIGN;
            align_tmr_d = '0;
        end

        // Count the attempt even when it is the one that exhausts the budget.
        if (enter_buf_rst) begin
            retry_d  = (retry_q == 8'hff) ? retry_q : retry_q + 8'd1;
            consec_d = consec_q + CRW'(1);
            if (consec_q >= CRW'(g_MAX_RETRIES)) begin
                state_d = ST_FAIL;
            end else begin
                state_d   = ST_BUF_RST;
                buf_cnt_d = '0;
            end
        end

        // Control outputs are decoded from the next state so they line up
        // with state_o after the register.
        realign_d = (state_d == ST_ALIGN);
        buf_rst_d = (state_d == ST_BUF_RST);
        up_d      = (state_d == ST_UP);
        fail_d    = (state_d == ST_FAIL);
    end

    always_ff @(posedge usrclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_WAIT_GT;
            align_tmr_q  <= '0;
            stable_cnt_q <= '0;
            buf_cnt_q    <= '0;
            consec_q     <= '0;
            retry_q      <= '0;
            realign_q    <= 1'b0;
            buf_rst_q    <= 1'b0;
            up_q         <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            align_tmr_q  <= align_tmr_d;
            stable_cnt_q <= stable_cnt_d;
            buf_cnt_q    <= buf_cnt_d;
            consec_q     <= consec_d;
            retry_q      <= retry_d;
            realign_q    <= realign_d;
            buf_rst_q    <= buf_rst_d;
            up_q         <= up_d;
            fail_q       <= fail_d;
        end
    end

    assign rx_realign_o   = realign_q;
    assign rx_buf_reset_o = buf_rst_q;
    assign link_up_o      = up_q;
    assign link_fail_o    = fail_q;
    assign retry_cnt_o    = retry_q;
    assign state_o        = state_q;

    gtp_tx_idle_sched #(
        .g_IDLE        (g_IDLE),
        .g_IDLE_K      (g_IDLE_K),
        .g_IDLE_PERIOD (g_IDLE_PERIOD)
    ) u_tx_sched (
        .usrclk_i   (usrclk_i),
        .rst_n_i    (rst_n_i),
        .link_up_i  (up_q),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_k_o     (tx_k_o)
    );

endmodule

// File: tb/tb_gtp_link_ctrl.sv
// Bench for gtp_link_ctrl: table-driven bring-up vectors followed by
// hand-written sequences for TX scheduling, recovery, FAIL and async reset.
module tb_gtp_link_ctrl;

    localparam int PERIOD = 5;

    logic        usrclk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        gt_reset_done_i = 1'b0;
    logic        rx_aligned_i = 1'b0;
    logic [2:0]  rx_bufstatus_i = 3'b000;
    logic [15:0] rx_data_i = 16'h0000;
    logic [1:0]  rx_k_i = 2'b00;
    logic        rx_realign_o, rx_buf_reset_o;
    logic [15:0] tx_data_i = 16'h0000;
    logic        tx_valid_i = 1'b0;
    logic        tx_ready_o;
    logic [15:0] tx_data_o;
    logic [1:0]  tx_k_o;
    logic        link_up_o, link_fail_o;
    logic [7:0]  retry_cnt_o;
    logic [2:0]  state_o;

    gtp_link_ctrl #(.g_IDLE_PERIOD(PERIOD)) dut (
        .usrclk_i        (usrclk_i),
        .rst_n_i         (rst_n_i),
        .gt_reset_done_i (gt_reset_done_i),
        .rx_aligned_i    (rx_aligned_i),
        .rx_bufstatus_i  (rx_bufstatus_i),
        .rx_data_i       (rx_data_i),
        .rx_k_i          (rx_k_i),
        .rx_realign_o    (rx_realign_o),
        .rx_buf_reset_o  (rx_buf_reset_o),
        .tx_data_i       (tx_data_i),
        .tx_valid_i      (tx_valid_i),
        .tx_ready_o      (tx_ready_o),
        .tx_data_o       (tx_data_o),
        .tx_k_o          (tx_k_o),
        .link_up_o       (link_up_o),
        .link_fail_o     (link_fail_o),
        .retry_cnt_o     (retry_cnt_o),
        .state_o         (state_o)
    );

    always #5 usrclk_i = ~usrclk_i;

    int total = 0;
    int bad = 0;
    int m_slot = 0;  // bench model of the TX slot counter

    typedef struct {
        logic        gt;
        logic        al;
        logic [2:0]  bs;
        logic [15:0] rd;
        logic [1:0]  rk;
        int          n;
        logic [2:0]  st;
        logic        realign;
        logic        up;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge usrclk_i);
            if (rst_n_i) m_slot = (m_slot == PERIOD - 1) ? 0 : m_slot + 1;
            #1;
        end
    endtask

    // Counts cycles rx_buf_reset_o stays high, bounded.
    task automatic pulse_len(output int cnt);
        cnt = 0;
        while (rx_buf_reset_o && cnt < 20) begin
            cnt++;
            tick(1);
        end
    endtask

    initial begin
        int cnt;
        logic [15:0] d;
        logic exp_rdy;

        //           gt    al    bs      rd        rk     n    st    rlgn  up
        tbl[0] = '{1'b0, 1'b0, 3'b000, 16'h0000, 2'b00, 10,  3'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 3'b000, 16'h0000, 2'b00, 1,   3'd1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 3'b000, 16'h0000, 2'b00, 49,  3'd1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 3'b000, 16'h1234, 2'b00, 1,   3'd2, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 3'b000, 16'h1234, 2'b00, 255, 3'd2, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 3'b000, 16'h1234, 2'b00, 1,   3'd3, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 3'b000, 16'hbc95, 2'b10, 3,   3'd3, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 3'b000, 16'h0000, 2'b00, 1,   3'd0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 3'b000, 16'h0000, 2'b00, 2,   3'd2, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 3'b000, 16'h0000, 2'b00, 256, 3'd3, 1'b0, 1'b1};

        // Reset state
        tick(3);
        chk("rst_state", state_o, 3'd0);
        chk("rst_tx_data", tx_data_o, 16'hbc95);
        chk("rst_tx_k", tx_k_o, 2'b10);
        chk("rst_realign", rx_realign_o, 1'b0);
        chk("rst_bufrst", rx_buf_reset_o, 1'b0);
        chk("rst_up", link_up_o, 1'b0);
        chk("rst_fail", link_fail_o, 1'b0);
        chk("rst_retry", retry_cnt_o, 8'd0);
        chk("rst_ready", tx_ready_o, 1'b0);
        rst_n_i = 1'b1;

        // Bring-up vectors
        for (int i = 0; i < 10; i++) begin
            gt_reset_done_i = tbl[i].gt;
            rx_aligned_i    = tbl[i].al;
            rx_bufstatus_i  = tbl[i].bs;
            rx_data_i       = tbl[i].rd;
            rx_k_i          = tbl[i].rk;
            tick(tbl[i].n);
            chk($sformatf("vec%0d_state", i), state_o, tbl[i].st);
            chk($sformatf("vec%0d_realign", i), rx_realign_o, tbl[i].realign);
            chk($sformatf("vec%0d_up", i), link_up_o, tbl[i].up);
            chk($sformatf("vec%0d_retry", i), retry_cnt_o, 8'd0);
            chk($sformatf("vec%0d_txk", i), tx_k_o, 2'b10);
        end

        // TX scheduling in UP, valid held high
        tx_valid_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            exp_rdy = (m_slot != 0);
            chk("tx_ready", tx_ready_o, exp_rdy);
            d = 16'($urandom);
            tx_data_i = d;
            tick(1);
            chk("tx_data", tx_data_o, exp_rdy ? d : 16'hbc95);
            chk("tx_k", tx_k_o, exp_rdy ? 2'b00 : 2'b10);
        end

        // Buffer overflow in UP -> 8-cycle pulse -> ALIGN
        rx_bufstatus_i = 3'b110;
        tick(1);
        rx_bufstatus_i = 3'b000;
        chk("ovf_state", state_o, 3'd4);
        chk("ovf_retry", retry_cnt_o, 8'd1);
        chk("ovf_ready", tx_ready_o, 1'b0);
        pulse_len(cnt);
        chk("ovf_pulse_len", cnt, 8);
        chk("ovf_after_state", state_o, 3'd1);
        chk("ovf_idle_k", tx_k_o, 2'b10);
        chk("ovf_idle_data", tx_data_o, 16'hbc95);
        tx_valid_i = 1'b0;

        // Comma in wrong byte during STABLE -> BUF_RST
        tick(1);
        chk("stb_state", state_o, 3'd2);
        rx_k_i = 2'b01;
        rx_data_i = 16'h95bc;
        tick(1);
        rx_k_i = 2'b00;
        rx_data_i = 16'h0000;
        chk("badk_state", state_o, 3'd4);
        chk("badk_retry", retry_cnt_o, 8'd2);
        pulse_len(cnt);
        chk("badk_pulse_len", cnt, 8);
        tick(257);
        chk("reup_state", state_o, 3'd3);
        chk("reup_retry", retry_cnt_o, 8'd2);

        // Four align timeouts: three pulses then FAIL (needs consec cleared in UP)
        rx_aligned_i = 1'b0;
        tick(1);
        chk("lose_align_state", state_o, 3'd1);
        for (int r = 0; r < 4; r++) begin
            cnt = 0;
            while (state_o == 3'd1 && cnt < 5000) begin
                cnt++;
                tick(1);
            end
            chk($sformatf("tmo%0d_len", r), cnt, 4096);
            if (r < 3) begin
                chk($sformatf("tmo%0d_state", r), state_o, 3'd4);
                pulse_len(cnt);
                chk($sformatf("tmo%0d_pulse", r), cnt, 8);
                chk($sformatf("tmo%0d_back", r), state_o, 3'd1);
            end
        end
        chk("fail_state", state_o, 3'd5);
        chk("fail_flag", link_fail_o, 1'b1);
        chk("fail_retry", retry_cnt_o, 8'd6);
        chk("fail_realign", rx_realign_o, 1'b0);
        chk("fail_bufrst", rx_buf_reset_o, 1'b0);
        chk("fail_up", link_up_o, 1'b0);
        gt_reset_done_i = 1'b0;
        tick(3);
        chk("fail_gt_low", state_o, 3'd5);
        gt_reset_done_i = 1'b1;
        tick(3);
        chk("fail_gt_high", state_o, 3'd5);
        chk("fail_sticky", link_fail_o, 1'b1);

        // Fresh bring-up, simultaneous buffer error + align loss, then async reset mid-pulse
        rst_n_i = 1'b0;
        m_slot = 0;
        tick(2);
        chk("rst2_fail", link_fail_o, 1'b0);
        rst_n_i = 1'b1;
        rx_aligned_i = 1'b1;
        tick(2);
        chk("rst2_stable", state_o, 3'd2);
        rx_aligned_i = 1'b0;
        rx_bufstatus_i = 3'b101;
        tick(1);
        chk("simul_state", state_o, 3'd4);
        chk("simul_retry", retry_cnt_o, 8'd1);
        rx_aligned_i = 1'b1;
        rx_bufstatus_i = 3'b000;
        tick(3);
        chk("mid_pulse", rx_buf_reset_o, 1'b1);
        #3;
        rst_n_i = 1'b0;
        #1;
        chk("async_bufrst", rx_buf_reset_o, 1'b0);
        chk("async_state", state_o, 3'd0);
        chk("async_tx_data", tx_data_o, 16'hbc95);
        chk("async_tx_k", tx_k_o, 2'b10);
        chk("async_retry", retry_cnt_o, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gtp_link_ctrl.md
Name: gtp_link_ctrl

Overview:
Link bring-up and supervision controller for one GTP lane running a 16-bit 8b/10b stream with an RX elastic buffer.
- Sequences the lane: wait for GT reset done, request comma realignment, qualify a stable stream, declare the link up.
- Recovers from alignment loss and buffer over/underflow by pulsing an RX buffer reset, within a bounded retry budget.
- Schedules TX: inserts IDLE (comma) words periodically for clock correction and gates user data onto the lane only while the link is up.

Parameters:
g_IDLE, 16'hbc95, IDLE word; comma in the upper byte
g_IDLE_K, 2'b10, charisk pattern of the IDLE word
g_IDLE_PERIOD, 193, TX slot period; slot 0 of each period is always IDLE (>=2)
g_ALIGN_TIMEOUT, 4096, cycles allowed in ALIGN before recovery
g_STABLE_CYCLES, 256, consecutive clean RX words required before UP
g_BUF_RST_CYCLES, 8, width of the rx_buf_reset_o pulse
g_MAX_RETRIES, 3, consecutive recoveries allowed before FAIL

Ports:
usrclk_i  in  1  user clock; all logic on the rising edge
rst_n_i  in  1  asynchronous active-low reset
gt_reset_done_i  in  1  GT TX/RX reset sequence complete
rx_aligned_i  in  1  GT comma-aligned indication
rx_bufstatus_i  in  3  GT RX elastic buffer status
rx_data_i  in  16  received word
rx_k_i  in  2  received charisk
rx_realign_o  out  1  request comma realignment
rx_buf_reset_o  out  1  RX elastic buffer reset pulse
tx_data_i  in  16  user TX word
tx_valid_i  in  1  user TX word valid
tx_ready_o  out  1  user word accepted this cycle if valid
tx_data_o  out  16  word to GT
tx_k_o  out  2  charisk to GT
link_up_o  out  1  high in state UP
link_fail_o  out  1  sticky: retry budget exhausted
retry_cnt_o  out  8  total recoveries since reset, saturating at 255
state_o  out  3  WAIT_GT=0, ALIGN=1, STABLE=2, UP=3, BUF_RST=4, FAIL=5

Behaviour:
- Reset (async, rst_n_i=0):
  - state WAIT_GT; all counters cleared.
  - tx_data_o=g_IDLE, tx_k_o=g_IDLE_K.
  - rx_realign_o, rx_buf_reset_o, link_up_o, link_fail_o = 0; retry_cnt_o=0.
- Outputs are registered. tx_ready_o is combinational from registered state and slot counter.
- Clean word: rx_k_i==00, or (rx_k_i==g_IDLE_K and rx_data_i==g_IDLE). Any other K pattern is bad.
- Buffer error: rx_bufstatus_i==3'b101 or 3'b110.
- State transitions, evaluated each cycle in priority order:
  - Any state except FAIL: gt_reset_done_i==0 -> WAIT_GT.
  - WAIT_GT: gt_reset_done_i==1 -> ALIGN; the align timer is cleared on entry.
  - ALIGN: rx_realign_o=1.
    - rx_aligned_i==1 -> STABLE; stable counter cleared.
    - Otherwise, timer reaching g_ALIGN_TIMEOUT-1 -> BUF_RST.
  - STABLE:
    - rx_aligned_i==0 -> ALIGN.
    - Buffer error or bad word -> BUF_RST.
    - Clean word increments the stable counter; on reaching g_STABLE_CYCLES -> UP and the consecutive-retry counter is cleared.
  - UP: link_up_o=1.
    - rx_aligned_i==0 -> ALIGN.
    - Buffer error or bad word -> BUF_RST.
  - BUF_RST: rx_buf_reset_o=1 for exactly g_BUF_RST_CYCLES cycles.
    - On entry, increment retry_cnt_o (saturating) and the consecutive counter.
    - If the consecutive count exceeds g_MAX_RETRIES -> FAIL instead of pulsing.
    - After the pulse -> ALIGN.
  - FAIL: link_fail_o=1; all other control outputs 0. Exits only via rst_n_i.
- Simultaneous events: buffer error plus alignment loss in the same cycle -> BUF_RST takes priority. Loss of gt_reset_done_i overrides everything except FAIL.
- TX scheduler:
  - Slot counter runs 0..g_IDLE_PERIOD-1 and wraps. It is free-running in every state, including during reset release.
  - tx_ready_o = link_up_o && slot!=0.
  - Next cycle: tx_data_o=tx_data_i, tx_k_o=00 if tx_valid_i && tx_ready_o; otherwise IDLE. Latency is 1 cycle.
  - Leaving UP forces IDLE from the next cycle. No user word is accepted in that cycle, because tx_ready_o is already low.

Decomposition:
- Shared package: state encoding constants, bufstatus codes (3'b101 underflow, 3'b110 overflow), IDLE word/K defaults.
- One sub-module: gtp_tx_idle_sched, containing the slot counter, tx_ready_o and the TX mux. It takes link_up as input.

Test Plan:
- gt_reset_done_i rises at cycle 10; rx_aligned_i rises 50 cycles later; then 256 clean words -> state_o 0->1->2->3, link_up_o=1, rx_realign_o=1 only in ALIGN, retry_cnt_o=0.
- In UP with g_IDLE_PERIOD=5 and tx_valid_i=1 constant -> tx_k_o=10/tx_data_o=bc95 every 5th cycle; the other 4 cycles carry tx_data_i delayed by 1 cycle with tx_k_o=00.
- In UP, drive rx_bufstatus_i=3'b110 for 1 cycle -> state 4, rx_buf_reset_o high exactly 8 cycles, retry_cnt_o=1, then state 1.
- rx_aligned_i held 0 for 4096 cycles in ALIGN, repeated 4 times -> three BUF_RST pulses, then link_fail_o=1, state 5; state stays 5 after gt_reset_done_i toggles.
- In STABLE, inject rx_k_i=01 with rx_data_i=95bc (comma in wrong byte) -> BUF_RST. After recovery and reaching UP, the consecutive counter is cleared while retry_cnt_o keeps its total.
- Assert rst_n_i low mid-BUF_RST pulse -> rx_buf_reset_o=0 and tx_data_o=bc95 immediately (asynchronous), state 0.
